// File: rtl/sample_stream_checker.sv
// rtl/sample_stream_checker.sv - receive-side test-pattern, line-length and frame-length checker
module sample_stream_checker #(
   parameter int PIXELS_PER_LINE = 1280,
   parameter int LINES_PER_FRAME = 990
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        frame_start_i,
   input  logic        line_valid_i,
   input  logic        data_valid_i,
   input  logic [15:0] data_i,
   input  logic        clear_i,
   output logic        frame_done_o,
   output logic [9:0]  line_count_o,
   output logic [15:0] data_err_cnt_o,
   output logic [15:0] len_err_cnt_o,
   output logic        frame_err_o,
   output logic        first_err_valid_o,
   output logic [9:0]  first_err_line_o,
   output logic [11:0] first_err_word_o
);

   localparam logic [11:0] PPL = 12'(PIXELS_PER_LINE);
   localparam logic [9:0]  LPF = 10'(LINES_PER_FRAME);

   typedef enum logic [1:0] {IDLE, WAIT_LINE, IN_LINE} state_t;

   state_t      state;
   logic [9:0]  line_idx;
   logic [11:0] word_idx;

   logic        word_strobe;
   logic [11:0] check_word;
   logic        mismatch;
   logic        line_end;
   logic        frame_close;
   logic        len_err;
   logic [9:0]  line_inc;
   logic [9:0]  final_count;

   // Decode this cycle's events; a frame close pre-empts any word or line-end activity.
   always_comb begin
      word_strobe = 1'b0;
      check_word  = 12'd0;
      mismatch    = 1'b0;
      line_end    = 1'b0;
      frame_close = 1'b0;
      len_err     = 1'b0;
      line_inc    = (line_idx == 10'd1023) ? line_idx : line_idx + 10'd1;
      final_count = (state == IN_LINE) ? line_inc : line_idx;

      frame_close = (state != IDLE) && frame_start_i;
      word_strobe = (state != IDLE) && !frame_start_i && line_valid_i && data_valid_i;
      // A word arriving on the line-valid rising cycle is word 0 of the new line.
      check_word  = (state == WAIT_LINE) ? 12'd0 : word_idx;
      mismatch    = word_strobe && (data_i != {line_idx[3:0], check_word});
      line_end    = (state == IN_LINE) && !frame_start_i && !line_valid_i;
      // A line cut short by a frame start always counts as a length error.
      len_err     = (line_end && (word_idx != PPL)) || (frame_close && (state == IN_LINE));
   end

   // Stream tracking FSM plus registered error counters, flags and first-error capture.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state             <= IDLE;
         line_idx          <= 10'd0;
         word_idx          <= 12'd0;
         frame_done_o      <= 1'b0;
         line_count_o      <= 10'd0;
         data_err_cnt_o    <= 16'd0;
         len_err_cnt_o     <= 16'd0;
         frame_err_o       <= 1'b0;
         first_err_valid_o <= 1'b0;
         first_err_line_o  <= 10'd0;
         first_err_word_o  <= 12'd0;
      end else begin
         frame_done_o <= 1'b0;

         case (state)
            IDLE: begin
               if (frame_start_i) begin
                  state    <= WAIT_LINE;
                  line_idx <= 10'd0;
               end
            end
            WAIT_LINE: begin
               if (!frame_start_i && line_valid_i) begin
                  state    <= IN_LINE;
                  word_idx <= data_valid_i ? 12'd1 : 12'd0;
               end
            end
            IN_LINE: begin
               if (!frame_start_i) begin
                  if (!line_valid_i) begin
                     state    <= WAIT_LINE;
                     line_idx <= line_inc;
                  end else if (data_valid_i) begin
                     word_idx <= word_idx + 12'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         if (frame_close) begin
            state        <= WAIT_LINE;
            line_idx     <= 10'd0;
            line_count_o <= final_count;
            frame_done_o <= 1'b1;
         end

         // Clear beats any error recorded in the same cycle.
         if (clear_i) begin
            data_err_cnt_o    <= 16'd0;
            len_err_cnt_o     <= 16'd0;
            frame_err_o       <= 1'b0;
            first_err_valid_o <= 1'b0;
            first_err_line_o  <= 10'd0;
            first_err_word_o  <= 12'd0;
         end else begin
            if (mismatch) begin
               if (data_err_cnt_o != 16'hFFFF)
                  data_err_cnt_o <= data_err_cnt_o + 16'd1;
               if (!first_err_valid_o) begin
                  first_err_valid_o <= 1'b1;
                  first_err_line_o  <= line_idx;
                  first_err_word_o  <= check_word;
               end
            end
            if (len_err && (len_err_cnt_o != 16'hFFFF))
               len_err_cnt_o <= len_err_cnt_o + 16'd1;
            if (frame_close && (final_count != LPF))
               frame_err_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sample_stream_checker.sv
// tb/tb_sample_stream_checker.sv - directed self-checking bench for sample_stream_checker
module tb_sample_stream_checker;

   logic        clk = 1'b0;
   logic        reset_i = 1'b0;
   logic        frame_start_i = 1'b0;
   logic        line_valid_i = 1'b0;
   logic        data_valid_i = 1'b0;
   logic [15:0] data_i = 16'd0;
   logic        clear_i = 1'b0;
   logic        frame_done_o;
   logic [9:0]  line_count_o;
   logic [15:0] data_err_cnt_o;
   logic [15:0] len_err_cnt_o;
   logic        frame_err_o;
   logic        first_err_valid_o;
   logic [9:0]  first_err_line_o;
   logic [11:0] first_err_word_o;

   int errors = 0;
   int checks = 0;

   sample_stream_checker #(.PIXELS_PER_LINE(8), .LINES_PER_FRAME(6)) dut (
      .clk_i(clk), .reset_i(reset_i), .frame_start_i(frame_start_i),
      .line_valid_i(line_valid_i), .data_valid_i(data_valid_i), .data_i(data_i),
      .clear_i(clear_i), .frame_done_o(frame_done_o), .line_count_o(line_count_o),
      .data_err_cnt_o(data_err_cnt_o), .len_err_cnt_o(len_err_cnt_o),
      .frame_err_o(frame_err_o), .first_err_valid_o(first_err_valid_o),
      .first_err_line_o(first_err_line_o), .first_err_word_o(first_err_word_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs, clock it, and sample #1 after the edge.
   task automatic cyc(input logic fs, input logic lv, input logic dv,
                      input logic [15:0] d, input logic clr);
      frame_start_i = fs;
      line_valid_i  = lv;
      data_valid_i  = dv;
      data_i        = d;
      clear_i       = clr;
      @(posedge clk);
      #1;
   endtask

   // One line of n words for line l; word bad_w (if in range) replaced by bad_v.
   // A valid gap precedes word 3 and a stray data_valid accompanies the line end.
   task automatic send_line(input int l, input int n, input int bad_w, input logic [15:0] bad_v);
      logic [15:0] d;
      for (int w = 0; w < n; w++) begin
         if (w == 3) cyc(1'b0, 1'b1, 1'b0, 16'hDEAD, 1'b0);
         d = {l[3:0], w[11:0]};
         if (w == bad_w) d = bad_v;
         cyc(1'b0, 1'b1, 1'b1, d, 1'b0);
      end
      cyc(1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b0);
   endtask

   task automatic fstart(input logic clr);
      cyc(1'b1, 1'b0, 1'b0, 16'h0000, clr);
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_done", frame_done_o, 0);
      chk("rst_count", line_count_o, 0);
      chk("rst_derr", data_err_cnt_o, 0);
      chk("rst_lerr", len_err_cnt_o, 0);
      chk("rst_ferr", frame_err_o, 0);
      chk("rst_fvalid", first_err_valid_o, 0);
      reset_i = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);

      // Perfect frame of 6 lines x 8 words
      fstart(1'b0);
      chk("first_fs_no_done", frame_done_o, 0);
      for (int l = 0; l < 6; l++) send_line(l, 8, -1, 16'h0);
      fstart(1'b0);
      chk("good_done", frame_done_o, 1);
      chk("good_count", line_count_o, 6);
      chk("good_derr", data_err_cnt_o, 0);
      chk("good_lerr", len_err_cnt_o, 0);
      chk("good_ferr", frame_err_o, 0);
      cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      chk("done_pulse_end", frame_done_o, 0);

      // Data errors: line 3 word 5 (expects 16'h3005), then line 5 word 0
      for (int l = 0; l < 6; l++) begin
         if (l == 3)      send_line(l, 8, 5, 16'h0000);
         else if (l == 5) send_line(l, 8, 0, 16'hFFFF);
         else             send_line(l, 8, -1, 16'h0);
         if (l == 3) begin
            chk("derr_first_cnt", data_err_cnt_o, 1);
            chk("derr_first_line", first_err_line_o, 3);
            chk("derr_first_word", first_err_word_o, 5);
            chk("derr_first_valid", first_err_valid_o, 1);
         end
      end
      fstart(1'b0);
      chk("derr_cnt2", data_err_cnt_o, 2);
      chk("derr_keep_line", first_err_line_o, 3);
      chk("derr_keep_word", first_err_word_o, 5);
      chk("derr_lerr", len_err_cnt_o, 0);
      chk("derr_count", line_count_o, 6);
      chk("derr_ferr", frame_err_o, 0);
      cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
      chk("clr_derr", data_err_cnt_o, 0);
      chk("clr_fvalid", first_err_valid_o, 0);
      chk("clr_fword", first_err_word_o, 0);
      chk("clr_keep_count", line_count_o, 6);

      // Length errors: 7 words, 9 words, then four good lines
      send_line(0, 7, -1, 16'h0);
      chk("short_lerr", len_err_cnt_o, 1);
      send_line(1, 9, -1, 16'h0);
      for (int l = 2; l < 6; l++) send_line(l, 8, -1, 16'h0);
      fstart(1'b0);
      chk("len_lerr", len_err_cnt_o, 2);
      chk("len_derr", data_err_cnt_o, 0);
      chk("len_count", line_count_o, 6);
      chk("len_ferr", frame_err_o, 0);
      cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);

      // Frame start mid-line after 5 full lines + 3 words; junk data that cycle is ignored
      for (int l = 0; l < 5; l++) send_line(l, 8, -1, 16'h0);
      for (int w = 0; w < 3; w++) cyc(1'b0, 1'b1, 1'b1, {4'd5, 12'(w)}, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 16'h0000, 1'b0);
      chk("mid_done", frame_done_o, 1);
      chk("mid_count", line_count_o, 6);
      chk("mid_lerr", len_err_cnt_o, 1);
      chk("mid_derr", data_err_cnt_o, 0);
      chk("mid_ferr", frame_err_o, 0);
      fstart(1'b0);
      chk("b2b_done", frame_done_o, 1);
      chk("b2b_count", line_count_o, 0);
      chk("b2b_ferr", frame_err_o, 1);
      // Clear coincident with an erroneous frame close
      fstart(1'b1);
      chk("clrclose_done", frame_done_o, 1);
      chk("clrclose_count", line_count_o, 0);
      chk("clrclose_ferr", frame_err_o, 0);
      chk("clrclose_lerr", len_err_cnt_o, 0);

      // Saturation: 65540 mismatching words in one long line (line 0)
      for (int i = 0; i < 65540; i++) cyc(1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0);
      chk("sat_derr", data_err_cnt_o, 16'hFFFF);
      chk("sat_fline", first_err_line_o, 0);
      chk("sat_fword", first_err_word_o, 0);
      cyc(1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b1);
      chk("satclr_derr", data_err_cnt_o, 0);
      chk("satclr_fvalid", first_err_valid_o, 0);
      cyc(1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0);
      chk("after_clr_derr", data_err_cnt_o, 1);
      chk("after_clr_fword", first_err_word_o, 5);
      cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      chk("wrap_lerr", len_err_cnt_o, 1);

      // Asynchronous reset mid-line, between clock edges
      cyc(1'b0, 1'b1, 1'b1, 16'h1000, 1'b0);
      #3 reset_i = 1'b0;
      #1;
      chk("async_derr", data_err_cnt_o, 0);
      chk("async_lerr", len_err_cnt_o, 0);
      chk("async_fvalid", first_err_valid_o, 0);
      @(posedge clk);
      #1 reset_i = 1'b1;
      // Traffic before frame start is ignored
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, 16'hAAAA, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      chk("idle_derr", data_err_cnt_o, 0);
      chk("idle_lerr", len_err_cnt_o, 0);
      fstart(1'b0);
      chk("fresh_no_done", frame_done_o, 0);
      for (int l = 0; l < 6; l++) send_line(l, 8, -1, 16'h0);
      fstart(1'b0);
      chk("fresh_count", line_count_o, 6);
      chk("fresh_derr", data_err_cnt_o, 0);
      chk("fresh_ferr", frame_err_o, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sample_stream_checker.md
Name: sample_stream_checker

Overview:
- Receive-side counterpart of the on-chip test-pattern generator.
- Sits on the 16-bit pixel-word bus upstream of the USB3 FIFO bridge. It consumes frame-start, line-valid and word-valid strobes.
- Checks every word against the deterministic test pattern, checks line length and lines per frame, and exposes saturating error counters plus first-error location for firmware readback.

Parameters:
PIXELS_PER_LINE, 1280, expected valid words per line (1..4095)
LINES_PER_FRAME, 990, expected lines between consecutive frame starts (1..1023)

Ports:
clk_i  in  1  pixel clock; all logic on rising edge
reset_i  in  1  asynchronous, active-low reset
frame_start_i  in  1  single-cycle pulse, start of frame
line_valid_i  in  1  high for the duration of an active line
data_valid_i  in  1  data_i carries a pixel word this cycle (qualified by line_valid_i)
data_i  in  16  pixel word
clear_i  in  1  synchronous clear of error counters, sticky flags and first-error capture
frame_done_o  out  1  one-cycle pulse when a frame is closed
line_count_o  out  10  lines counted in last closed frame
data_err_cnt_o  out  16  data-mismatch count, saturates at 16'hFFFF
len_err_cnt_o  out  16  line-length-mismatch count, saturates at 16'hFFFF
frame_err_o  out  1  sticky: some closed frame had line count != LINES_PER_FRAME
first_err_valid_o  out  1  first_err_* fields hold a captured error
first_err_line_o  out  10  line index of first data mismatch since clear
first_err_word_o  out  12  word index of first data mismatch since clear

Behaviour:
- Reset (reset_i low, async): state IDLE; line_idx, word_idx, all outputs = 0.
- Expected word for word w of line l: {l[3:0], w[11:0]}.
- IDLE:
  - All inputs except frame_start_i are ignored.
  - frame_start_i -> WAIT_LINE with line_idx=0. No frame_done_o for this first frame start.
- WAIT_LINE:
  - line_valid_i high -> IN_LINE with word_idx=0.
  - If data_valid_i is high in that same cycle, the word is checked as word 0.
- IN_LINE, each cycle with data_valid_i & line_valid_i:
  - Compare data_i with the expected word.
  - On mismatch: data_err_cnt +1 (saturating). If first_err_valid_o=0, capture line_idx/word_idx and set first_err_valid_o.
  - word_idx +1, wrapping at 12 bits. The wrap is reflected in the length check only.
- IN_LINE, line_valid_i low:
  - If word_idx != PIXELS_PER_LINE, len_err_cnt +1 (saturating).
  - line_idx +1, saturating at 1023.
  - Go to WAIT_LINE.
- data_valid_i while line_valid_i low: ignored, no counting.
- frame_start_i in WAIT_LINE or IN_LINE (frame close):
  - Takes priority; data_i that cycle is ignored.
  - If in IN_LINE, the partial line counts as one line (line_idx+1) and one length error, regardless of word_idx.
  - line_count_o <= final line count.
  - frame_err_o set if final count != LINES_PER_FRAME.
  - frame_done_o pulses high the cycle after frame_start_i.
  - Then line_idx=0 and state WAIT_LINE.
  - Back-to-back frame_start_i pulses close an empty frame (count 0 -> frame_err_o).
- Output latency: counters, flags and first_err_* update on the clock edge after the sampled input, i.e. visible one cycle later.
- clear_i:
  - Zeroes data_err_cnt_o, len_err_cnt_o, frame_err_o, first_err_*.
  - Does not affect state, line_idx, word_idx or line_count_o.
  - Clear wins over an error or frame close occurring in the same cycle, but line_count_o and frame_done_o still update.
- Saturation: counters hold at 16'hFFFF; no wrap.
- Reset mid-line: returns to IDLE; the next frame_start_i begins fresh checking.

Test Plan:
- Reset, frame_start, then LINES_PER_FRAME perfect lines of PIXELS_PER_LINE words with 1-cycle valid gaps, then frame_start -> frame_done_o pulse 1 cycle later, line_count_o=990, both error counts 0, frame_err_o=0.
- Line 5, word 100 driven as 16'h0000 instead of 16'h5064 -> data_err_cnt_o=1, first_err_line_o=5, first_err_word_o=100. A second error on line 7 leaves the capture unchanged.
- Line of 1279 words, then line of 1281 words -> len_err_cnt_o=2, data_err_cnt_o=0.
- frame_start_i mid-line after 989 full lines + 10 words -> line_count_o=990, len_err_cnt_o=1, frame_err_o=0. Two back-to-back frame_start pulses -> line_count_o=0, frame_err_o=1.
- Force 70000 data mismatches -> data_err_cnt_o holds 16'hFFFF. clear_i coincident with a mismatch -> counter 0, first_err_valid_o=0.
- Assert reset_i low mid-line with no clock edge -> outputs 0 immediately. Release, and words arriving before frame_start_i produce no counts.
